// File: rtl/test_env_cmd_ctrl.sv
// rtl/test_env_cmd_ctrl.sv - byte-stream command controller driving the DUT test bus
//
// Receives fixed-length frames {OPC,SELF}, ADR, NB data bytes (MSB first) on the
// RX byte strobe, drives one DUT bus access (or a header fetch), then returns a
// status byte followed by the DUT data / header on the TX byte stream.
//
// Ports:
//   CLK_SYS, RST              clock, asynchronous active-high reset
//   RX_DATA, RX_VALID         host byte input, one-cycle strobe
//   TX_DATA, TX_VALID, TX_READY  host byte output, valid/ready handshake
//   SEL, ADR, RnW, DATA_IN    DUT bus request lines (SEL=0 selects nothing)
//   START_FLAG                one-cycle access start pulse
//   DATA_OUT, HEAD_INFO, RDY_FLAG  response lines of the selected DUT
//   BUSY                      high whenever the controller is not idle
module test_env_cmd_ctrl #(
  parameter int BITWIDTH_DATA     = 16,
  parameter int BITWIDTH_ADR      = 6,
  parameter int NUM_DUT           = 3,
  parameter int NUM_BITS_HEADER   = 32,
  parameter int TIMEOUT_CYC       = 1000,
  parameter int FRAME_TIMEOUT_CYC = 100000
) (
  input  logic                       CLK_SYS,
  input  logic                       RST,
  input  logic [7:0]                 RX_DATA,
  input  logic                       RX_VALID,
  output logic [7:0]                 TX_DATA,
  output logic                       TX_VALID,
  input  logic                       TX_READY,
  output logic [$clog2(NUM_DUT):0]   SEL,
  output logic [BITWIDTH_ADR-1:0]    ADR,
  output logic                       RnW,
  output logic [BITWIDTH_DATA-1:0]   DATA_IN,
  output logic                       START_FLAG,
  input  logic [BITWIDTH_DATA-1:0]   DATA_OUT,
  input  logic [NUM_BITS_HEADER-1:0] HEAD_INFO,
  input  logic                       RDY_FLAG,
  output logic                       BUSY
);

  localparam int NB = BITWIDTH_DATA / 8;
  localparam int NH = NUM_BITS_HEADER / 8;
  localparam int SW = $clog2(NUM_DUT) + 1;
  localparam int PW = (BITWIDTH_DATA > NUM_BITS_HEADER) ? BITWIDTH_DATA : NUM_BITS_HEADER;
  localparam int CW = $clog2(PW / 8 + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(FRAME_TIMEOUT_CYC + 1);

  localparam logic [1:0] OPC_READ = 2'd1;
  localparam logic [1:0] OPC_HEAD = 2'd3;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_RX_ADR     = 4'd1;
  localparam logic [3:0] S_RX_DATA    = 4'd2;
  localparam logic [3:0] S_CHECK      = 4'd3;
  localparam logic [3:0] S_EXEC       = 4'd4;
  localparam logic [3:0] S_WAIT_RDY   = 4'd5;
  localparam logic [3:0] S_HEAD1      = 4'd6;
  localparam logic [3:0] S_HEAD2      = 4'd7;
  localparam logic [3:0] S_TX_STATUS  = 4'd8;
  localparam logic [3:0] S_TX_PAYLOAD = 4'd9;

  logic [3:0]               state;
  logic [1:0]               opc;
  logic [5:0]               self_f;
  logic [BITWIDTH_ADR-1:0]  adr_r;
  logic [BITWIDTH_DATA-1:0] data_r;
  logic [CW-1:0]            rx_cnt;
  logic [CW-1:0]            tx_cnt;
  logic [FW-1:0]            gap_cnt;
  logic [TW-1:0]            wait_cnt;
  logic [PW-1:0]            payload;
  logic                     rdy_prev;
  logic                     drop;
  logic                     timeout_f;
  logic                     sel_inv;

  logic          in_rx;
  logic          frame_tmo;
  logic          drop_set;
  logic          tx_fire;
  logic          self_bad;
  logic [CW-1:0] pl_len;

  assign BUSY      = (state != S_IDLE);
  assign in_rx     = (state == S_RX_ADR) || (state == S_RX_DATA);
  // The gap counter saturates at the limit, so the discard fires exactly once
  // and takes precedence over a byte arriving in the same cycle.
  assign frame_tmo = in_rx && (gap_cnt == FW'(FRAME_TIMEOUT_CYC));
  assign drop_set  = RX_VALID && (!(in_rx || state == S_IDLE) || frame_tmo);
  assign tx_fire   = TX_VALID && TX_READY;
  assign self_bad  = (self_f == 6'd0) || (int'(self_f) > NUM_DUT);
  assign pl_len    = (opc == OPC_HEAD) ? CW'(NH) : CW'(NB);

  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      opc        <= '0;
      self_f     <= '0;
      adr_r      <= '0;
      data_r     <= '0;
      rx_cnt     <= '0;
      tx_cnt     <= '0;
      gap_cnt    <= '0;
      wait_cnt   <= '0;
      payload    <= '0;
      rdy_prev   <= 1'b0;
      drop       <= 1'b0;
      timeout_f  <= 1'b0;
      sel_inv    <= 1'b0;
      TX_DATA    <= '0;
      TX_VALID   <= 1'b0;
      SEL        <= '0;
      ADR        <= '0;
      RnW        <= 1'b0;
      DATA_IN    <= '0;
      START_FLAG <= 1'b0;
    end else begin
      START_FLAG <= 1'b0;
      case (state)
        S_IDLE: begin
          if (RX_VALID) begin
            opc       <= RX_DATA[7:6];
            self_f    <= RX_DATA[5:0];
            timeout_f <= 1'b0;
            sel_inv   <= 1'b0;
            gap_cnt   <= '0;
            state     <= S_RX_ADR;
          end
        end
        S_RX_ADR: begin
          if (frame_tmo) begin
            state <= S_IDLE;
          end else if (RX_VALID) begin
            adr_r   <= RX_DATA[BITWIDTH_ADR-1:0];
            gap_cnt <= '0;
            rx_cnt  <= '0;
            state   <= S_RX_DATA;
          end else begin
            gap_cnt <= gap_cnt + FW'(1);
          end
        end
        S_RX_DATA: begin
          if (frame_tmo) begin
            state <= S_IDLE;
          end else if (RX_VALID) begin
            data_r  <= BITWIDTH_DATA'({data_r, RX_DATA});
            gap_cnt <= '0;
            if (rx_cnt == CW'(NB - 1)) state <= S_CHECK;
            else rx_cnt <= rx_cnt + CW'(1);
          end else begin
            gap_cnt <= gap_cnt + FW'(1);
          end
        end
        S_CHECK: begin
          if (self_bad) begin
            sel_inv <= 1'b1;
            payload <= '0;
            state   <= S_TX_STATUS;
          end else if (opc == OPC_HEAD) begin
            SEL   <= self_f[SW-1:0];
            state <= S_HEAD1;
          end else begin
            SEL        <= self_f[SW-1:0];
            ADR        <= adr_r;
            RnW        <= (opc == OPC_READ);
            DATA_IN    <= data_r;
            START_FLAG <= 1'b1;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rdy_prev <= RDY_FLAG;
          wait_cnt <= '0;
          state    <= S_WAIT_RDY;
        end
        S_WAIT_RDY: begin
          rdy_prev <= RDY_FLAG;
          // Only a fresh rising edge counts; a level left high by an earlier
          // access must not complete this one.
          if (RDY_FLAG && !rdy_prev) begin
            payload <= PW'(DATA_OUT) << (PW - BITWIDTH_DATA);
            SEL     <= '0;
            state   <= S_TX_STATUS;
          end else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
            timeout_f <= 1'b1;
            payload   <= '0;
            SEL       <= '0;
            state     <= S_TX_STATUS;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_HEAD1: state <= S_HEAD2;
        S_HEAD2: begin
          payload <= PW'(HEAD_INFO) << (PW - NUM_BITS_HEADER);
          SEL     <= '0;
          state   <= S_TX_STATUS;
        end
        S_TX_STATUS: begin
          if (!TX_VALID) begin
            TX_VALID <= 1'b1;
            TX_DATA  <= {4'hA, 1'b0, drop, timeout_f, sel_inv};
          end else if (TX_READY) begin
            TX_DATA <= payload[PW-1 -: 8];
            payload <= payload << 8;
            tx_cnt  <= CW'(1);
            state   <= S_TX_PAYLOAD;
          end
        end
        S_TX_PAYLOAD: begin
          if (TX_READY) begin
            if (tx_cnt == pl_len) begin
              TX_VALID <= 1'b0;
              TX_DATA  <= '0;
              state    <= S_IDLE;
            end else begin
              TX_DATA <= payload[PW-1 -: 8];
              payload <= payload << 8;
              tx_cnt  <= tx_cnt + CW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Clear only the drop that was actually reported in the status byte now
      // leaving; a byte dropped while that status is on the link is kept.
      if (drop_set) drop <= 1'b1;
      else if (state == S_TX_STATUS && tx_fire) drop <= drop & ~TX_DATA[2];
    end
  end

endmodule

// File: tb/tb_test_env_cmd_ctrl.sv
// tb/tb_test_env_cmd_ctrl.sv - randomized self-checking bench for test_env_cmd_ctrl
module tb_test_env_cmd_ctrl;

  localparam int W    = 16;
  localparam int AW   = 6;
  localparam int ND   = 3;
  localparam int HW   = 32;
  localparam int TMO  = 16;
  localparam int FTMO = 40;
  localparam int NB   = W / 8;
  localparam int NH   = HW / 8;
  localparam int SW   = $clog2(ND) + 1;

  logic          CLK_SYS = 1'b0;
  logic          RST;
  logic [7:0]    RX_DATA;
  logic          RX_VALID;
  logic [7:0]    TX_DATA;
  logic          TX_VALID;
  logic          TX_READY;
  logic [SW-1:0] SEL;
  logic [AW-1:0] ADR;
  logic          RnW;
  logic [W-1:0]  DATA_IN;
  logic          START_FLAG;
  logic [W-1:0]  DATA_OUT;
  logic [HW-1:0] HEAD_INFO;
  logic          RDY_FLAG;
  logic          BUSY;

  test_env_cmd_ctrl #(
    .BITWIDTH_DATA(W), .BITWIDTH_ADR(AW), .NUM_DUT(ND), .NUM_BITS_HEADER(HW),
    .TIMEOUT_CYC(TMO), .FRAME_TIMEOUT_CYC(FTMO)
  ) dut (
    .CLK_SYS(CLK_SYS), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .SEL(SEL), .ADR(ADR), .RnW(RnW), .DATA_IN(DATA_IN), .START_FLAG(START_FLAG),
    .DATA_OUT(DATA_OUT), .HEAD_INFO(HEAD_INFO), .RDY_FLAG(RDY_FLAG), .BUSY(BUSY)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // DUT-side model: RnW=0 stores and echoes, RnW=1 returns storage.
  logic [W-1:0]  dut_mem [0:7][0:63];
  logic [W-1:0]  ref_mem [0:7][0:63];
  logic [HW-1:0] head_tbl [0:7];
  int            rdy_mode = 0;   // 0 normal, 1 stuck high, 2 never
  int            rdy_delay = 3;
  int            rdy_timer = -1;
  int            start_cnt = 0;
  int            sel_cycles = 0;
  logic [SW-1:0] cap_sel;
  logic [AW-1:0] cap_adr;
  logic          cap_rnw;
  logic [W-1:0]  cap_data;
  logic [W-1:0]  resp;

  assign HEAD_INFO = head_tbl[SEL];

  always @(negedge CLK_SYS) begin
    if (SEL != '0) sel_cycles++;
    if (rdy_mode == 1) RDY_FLAG = 1'b1;
    if (START_FLAG) begin
      start_cnt++;
      cap_sel  = SEL;
      cap_adr  = ADR;
      cap_rnw  = RnW;
      cap_data = DATA_IN;
      RDY_FLAG = (rdy_mode == 1);
      if (RnW) resp = dut_mem[SEL][ADR];
      else begin
        dut_mem[SEL][ADR] = DATA_IN;
        resp = DATA_IN;
      end
      rdy_timer = (rdy_mode == 0) ? rdy_delay : -1;
    end else if (rdy_timer > 0) begin
      rdy_timer--;
      if (rdy_timer == 0) begin
        check("bus_hold", {SEL, ADR, RnW, DATA_IN}, {cap_sel, cap_adr, cap_rnw, cap_data});
        DATA_OUT  = resp;
        RDY_FLAG  = 1'b1;
        rdy_timer = -1;
      end
    end
  end

  // Host TX sink with configurable backpressure per byte.
  logic [7:0] tx_q [$];
  int         bp_cycles = 0;
  int         bp_ctr = 0;
  bit         held = 0;
  logic [7:0] held_data;

  always @(negedge CLK_SYS) begin
    if (held) begin
      check("tx_hold_valid", TX_VALID, 1'b1);
      check("tx_hold_data", TX_DATA, held_data);
    end
    if (TX_VALID) begin
      if (bp_ctr < bp_cycles) begin
        TX_READY  = 1'b0;
        bp_ctr++;
        held      = 1;
        held_data = TX_DATA;
      end else begin
        TX_READY = 1'b1;
        tx_q.push_back(TX_DATA);
        bp_ctr = 0;
        held   = 0;
      end
    end else begin
      TX_READY = 1'b0;
      bp_ctr   = 0;
      held     = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK_SYS);
    RX_VALID = 1'b1;
    RX_DATA  = b;
    @(negedge CLK_SYS);
    RX_VALID = 1'b0;
  endtask

  bit exp_drop = 0;

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [W-1:0] d, input bit inject, input string tag);
    logic [1:0]    opc;
    int            self;
    bit            inv;
    int            len;
    logic [7:0]    st;
    logic [63:0]   pl;
    logic [7:0]    exp_q [$];
    int            s0;
    bit            fin;
    bit            inj_done;
    logic [W-1:0]  dv;
    opc  = b0[7:6];
    self = int'(b0[5:0]);
    inv  = (self == 0) || (self > ND);
    len  = (opc == 2'd3) ? NH : NB;
    st   = 8'hA0 | (exp_drop ? 8'h04 : 8'h00) | (inv ? 8'h01 : 8'h00)
         | ((!inv && opc != 2'd3 && rdy_mode == 1) ? 8'h02 : 8'h00);
    if (inv || (opc != 2'd3 && rdy_mode == 1)) pl = 0;
    else if (opc == 2'd3) pl = 64'(head_tbl[self]);
    else if (opc == 2'd1) pl = 64'(ref_mem[self][b1[AW-1:0]]);
    else pl = 64'(d);
    if (!inv && opc != 2'd1 && opc != 2'd3) ref_mem[self][b1[AW-1:0]] = d;
    exp_q.push_back(st);
    for (int i = len - 1; i >= 0; i--) exp_q.push_back(8'(pl >> (8 * i)));

    s0 = start_cnt;
    tx_q.delete();
    sel_cycles = 0;
    send_byte(b0);
    send_byte(b1);
    dv = d;
    for (int i = NB - 1; i >= 0; i--) send_byte(8'(dv >> (8 * i)));

    fin = 0;
    inj_done = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK_SYS);
      RX_VALID = 1'b0;
      if (inject && !inj_done && tx_q.size() >= 1 && BUSY) begin
        RX_VALID = 1'b1;
        RX_DATA  = 8'h5A;
        inj_done = 1;
      end else if (!BUSY && !TX_VALID) begin
        fin = 1;
        break;
      end
    end
    RX_VALID = 1'b0;
    check({tag, "_done"}, fin, 1'b1);
    check({tag, "_txlen"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), tx_q[i], exp_q[i]);
    if (inv || opc == 2'd3) begin
      check({tag, "_nostart"}, start_cnt - s0, 0);
    end else begin
      check({tag, "_start"}, start_cnt - s0, 1);
      check({tag, "_bus"}, {cap_sel, cap_adr, cap_rnw, cap_data},
            {SW'(self), b1[AW-1:0], (opc == 2'd1), d});
    end
    if (opc == 2'd3 && !inv) check({tag, "_headsel"}, sel_cycles, 2);
    exp_drop = inject;
  endtask

  initial begin
    int s0;
    bit seen;
    RST = 1'b1; RX_DATA = '0; RX_VALID = 1'b0; TX_READY = 1'b0;
    DATA_OUT = '0; RDY_FLAG = 1'b0;
    for (int s = 0; s < 8; s++) begin
      head_tbl[s] = $urandom;
      for (int a = 0; a < 64; a++) begin
        dut_mem[s][a] = W'($urandom);
        ref_mem[s][a] = dut_mem[s][a];
      end
    end
    head_tbl[2] = 32'h03A1B2C3;
    dut_mem[3][5] = 16'hBEEF;
    ref_mem[3][5] = 16'hBEEF;

    repeat (3) @(negedge CLK_SYS);
    check("reset_outs", {TX_VALID, START_FLAG, SEL, BUSY, TX_DATA, ADR, RnW, DATA_IN}, 0);
    RST = 1'b0;
    @(negedge CLK_SYS);
    check("idle_busy", BUSY, 1'b0);

    // Reset while waiting for a DUT that never answers
    rdy_mode = 2;
    s0 = start_cnt;
    send_byte(8'h43); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (start_cnt != s0) begin seen = 1; break; end
      @(negedge CLK_SYS);
    end
    check("rst_wait_started", seen, 1'b1);
    repeat (3) @(negedge CLK_SYS);
    check("rst_wait_busy_before", BUSY, 1'b1);
    RST = 1'b1;
    @(negedge CLK_SYS);
    RST = 1'b0;
    #1;
    check("rst_wait_outs", {SEL, START_FLAG, TX_VALID, BUSY}, 0);
    rdy_mode = 0;

    rdy_delay = 3;
    run_frame(8'h81, 8'h00, 16'h1234, 0, "calc");

    bp_cycles = 5;
    run_frame(8'h43, 8'h05, 16'h0000, 0, "read_bp");
    bp_cycles = 0;

    rdy_mode = 1;
    run_frame(8'h82, 8'h07, 16'hCAFE, 0, "timeout");
    rdy_mode = 0;

    run_frame(8'h05, 8'h11, 16'h2222, 0, "badsel");
    run_frame(8'hC2, 8'h00, 16'h0000, 0, "head");

    bp_cycles = 2;
    run_frame(8'h81, 8'h01, 16'h5555, 1, "drop_inj");
    bp_cycles = 0;
    run_frame(8'h42, 8'h01, 16'h0000, 0, "drop_rep");
    run_frame(8'h41, 8'h02, 16'h0000, 0, "drop_clr");

    // Frame abandoned after two bytes
    s0 = start_cnt;
    tx_q.delete();
    send_byte(8'h81); send_byte(8'h00);
    repeat (FTMO + 5) @(negedge CLK_SYS);
    check("ftmo_idle", BUSY, 1'b0);
    check("ftmo_notx", tx_q.size(), 0);
    check("ftmo_nostart", start_cnt - s0, 0);
    run_frame(8'h03, 8'h09, 16'hA5A5, 0, "after_ftmo");

    for (int n = 0; n < 40; n++) begin
      logic [1:0] ro;
      logic [5:0] rs;
      ro = 2'($urandom_range(0, 3));
      rs = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 4));
      rdy_delay = $urandom_range(1, 6);
      bp_cycles = $urandom_range(0, 3);
      run_frame({ro, rs}, 8'($urandom), W'($urandom), 0, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_env_cmd_ctrl.md
Name: test_env_cmd_ctrl

Overview:
Byte-stream command controller placed directly upstream of the DUT test environment. It takes framed commands from the host link (UART/SPI byte interface) and drives the DUT select, address, read/write, data and start lines. It then waits for the selected DUT's ready flag and returns a status byte plus the DUT data or header to the host as a byte stream.

Parameters:
BITWIDTH_DATA, 16, DUT data width; multiple of 8, 8..32; NB = BITWIDTH_DATA/8
BITWIDTH_ADR, 6, DUT address width, ≤8
NUM_DUT, 3, number of DUTs; valid SEL range 1..NUM_DUT
NUM_BITS_HEADER, 32, header width; multiple of 8; NH = NUM_BITS_HEADER/8
TIMEOUT_CYC, 1000, maximum cycles to wait for RDY_FLAG
FRAME_TIMEOUT_CYC, 100000, maximum gap between bytes of one frame

Ports:
CLK_SYS  in  1  system clock
RST  in  1  asynchronous, active-high reset
RX_DATA  in  8  received byte
RX_VALID  in  1  one-cycle strobe, RX_DATA valid
TX_DATA  out  8  byte to send
TX_VALID  out  1  TX_DATA valid; held until TX_READY
TX_READY  in  1  link accepts byte when TX_VALID&&TX_READY
SEL  out  $clog2(NUM_DUT)+1  DUT select; 0 = none
ADR  out  BITWIDTH_ADR  DUT address
RnW  out  1  1 = read, 0 = write
DATA_IN  out  BITWIDTH_DATA  data to DUT
START_FLAG  out  1  one-cycle start pulse
DATA_OUT  in  BITWIDTH_DATA  data from selected DUT
HEAD_INFO  in  NUM_BITS_HEADER  header of selected DUT
RDY_FLAG  in  1  ready of selected DUT
BUSY  out  1  high outside IDLE

Behaviour:
- Reset: all outputs 0, FSM in IDLE, drop flag cleared, counters cleared. Reset mid-frame or mid-wait aborts without a response.
- Frame is fixed length, 2+NB bytes.
  - B0 = {OPC[1:0], SELF[5:0]}.
  - B1 = address; low BITWIDTH_ADR bits are used.
  - Then NB data bytes, MSB first.
- OPC values: 0 WRITE, 1 READ, 2 CALC, 3 HEAD.
- FSM states: IDLE → RX_ADR → RX_DATA (NB bytes) → CHECK → EXEC → WAIT_RDY → TX_STATUS → TX_PAYLOAD → IDLE.
- IDLE: a RX_VALID byte is taken as B0.
- In RX_ADR and RX_DATA, a gap of FRAME_TIMEOUT_CYC cycles without RX_VALID discards the frame and returns to IDLE with no response.
- CHECK (1 cycle): SELF==0 or SELF>NUM_DUT sets the sel_invalid bit and skips to TX_STATUS. The payload is then all zeros of the opcode's length.
- HEAD opcode: skips EXEC/WAIT_RDY. It sets SEL=SELF for 2 cycles, latches HEAD_INFO on the 2nd cycle, then goes to TX_STATUS.
- EXEC (1 cycle):
  - SEL=SELF, ADR=B1, DATA_IN = data bytes.
  - RnW=1 for READ, 0 for WRITE/CALC.
  - START_FLAG=1.
  - Samples RDY_FLAG as rdy_prev.
- Bus hold: SEL, ADR, RnW and DATA_IN stay stable from EXEC until WAIT_RDY exits. SEL returns to 0 on entry to TX_STATUS.
- WAIT_RDY:
  - Completion is the rising edge of RDY_FLAG (RDY_FLAG=1 and previous sample 0), so a stale high level is never accepted.
  - On completion, latch DATA_OUT and go to TX_STATUS.
  - After TIMEOUT_CYC cycles without completion, set the timeout bit, latch 0, go to TX_STATUS.
- Status byte = {4'hA, 1'b0, drop, timeout, sel_invalid}. drop clears after it is sent.
- Payload lengths: NB bytes for WRITE/READ/CALC (latched DATA_OUT, MSB first); NH bytes for HEAD (MSB first).
- TX handshake:
  - TX_VALID rises the cycle after entering TX_STATUS.
  - A byte advances only on TX_VALID&&TX_READY.
  - TX_DATA is stable while TX_VALID=1 and TX_READY=0.
  - After the last byte: TX_VALID=0, FSM to IDLE.
- RX_VALID outside IDLE/RX_ADR/RX_DATA: byte dropped, drop flag set (sticky until reported).
- RX_VALID in the same cycle as a frame timeout: the timeout wins and the byte is dropped. Timeout counters are unsigned and saturate.
- BUSY = (state != IDLE).

Test Plan:
- Reset while in WAIT_RDY (RST for 1 cycle) → SEL=0, START_FLAG=0, TX_VALID=0, BUSY=0; a following frame executes normally.
- CALC: RX 0x81,0x00,0x12,0x34, DUT echoes with RDY rising 3 cycles after START.
  - Exactly one START_FLAG pulse, with SEL=1 and DATA_IN=0x1234.
  - TX sequence is 0xA0,0x12,0x34.
- READ with TX backpressure: RX 0x43,0x05,0x00,0x00; DUT3 returns 0xBEEF; TX_READY low for 5 cycles per byte.
  - ADR=5, RnW=1.
  - TX sequence is 0xA0,0xBE,0xEF, each byte held stable during backpressure.
- Timeout: RDY_FLAG stuck high, TIMEOUT_CYC=16.
  - No rising edge is seen, so after 16 cycles TX is 0xA2,0x00,0x00.
- Invalid select: B0=0x05 (NUM_DUT=3) → no START_FLAG, TX 0xA1,0x00,0x00. HEAD with SEL=2 and HEAD_INFO=0x03A1B2C3 → TX 0xA0,0x03,0xA1,0xB2,0xC3.
- Robustness cases:
  - Extra byte during TX_PAYLOAD → next response status is 0xA4, then the flag clears.
  - Frame stopped after 2 bytes for FRAME_TIMEOUT_CYC → no TX, back to IDLE.
